// File: rtl/serial_display_driver.sv
// Serial frame transmitter for multi-register 7-segment driver chips.
// Shifts NUM_DIGITS words out on dout/sclk and strobes load after each word.
module serial_display_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int WORD_BITS  = 16,
    parameter int CLK_DIV    = 4,
    parameter int LSB_FIRST  = 0
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_en,
    input  logic                            i_start,
    input  logic [NUM_DIGITS*WORD_BITS-1:0] i_data,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_serial_dout,
    output logic                            o_serial_load,
    output logic                            o_serial_clk
);
    localparam int FRAME_W = NUM_DIGITS * WORD_BITS;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W   = $clog2(WORD_BITS);
    localparam int WORD_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_BITS - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t               r_state;
    logic [FRAME_W-1:0]   r_frame;
    logic [DIV_W-1:0]     r_div;
    logic [BIT_W-1:0]     r_bit;
    logic [WORD_W-1:0]    r_word;
    logic                 r_phase;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_dout;
    logic                 r_load;
    logic                 r_sclk;
    logic                 w_div_wrap;

    // Bit number n of word w in transmission order, honouring LSB_FIRST.
    function automatic logic frame_bit(input logic [FRAME_W-1:0] data,
                                       input int word, input int bitn);
        int                 pos;
        logic [FRAME_W-1:0] shifted;
        pos     = word * WORD_BITS + ((LSB_FIRST != 0) ? bitn : (WORD_BITS - 1 - bitn));
        shifted = data >> pos;
        return shifted[0];
    endfunction

    assign w_div_wrap = (r_div == DIV_LAST);

    // Frame sequencer: divider, bit/word counters and registered pin outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_frame <= {FRAME_W{1'b0}};
            r_div   <= {DIV_W{1'b0}};
            r_bit   <= {BIT_W{1'b0}};
            r_word  <= {WORD_W{1'b0}};
            r_phase <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dout  <= 1'b0;
            r_load  <= 1'b0;
            r_sclk  <= 1'b0;
        end else if (i_en) begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_frame <= i_data;
                        r_div   <= {DIV_W{1'b0}};
                        r_bit   <= {BIT_W{1'b0}};
                        r_word  <= {WORD_W{1'b0}};
                        r_phase <= 1'b0;
                        r_busy  <= 1'b1;
                        r_dout  <= frame_bit(i_data, 0, 0);
                        r_load  <= 1'b0;
                        r_sclk  <= 1'b0;
                        r_state <= S_SHIFT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    if (!w_div_wrap) begin
                        r_div <= r_div + DIV_W'(1);
                    end else if (!r_phase) begin
                        r_div   <= {DIV_W{1'b0}};
                        r_phase <= 1'b1;
                        r_sclk  <= 1'b1;
                    end else begin
                        r_div   <= {DIV_W{1'b0}};
                        r_phase <= 1'b0;
                        r_sclk  <= 1'b0;
                        if (r_bit == BIT_LAST) begin
                            r_bit   <= {BIT_W{1'b0}};
                            r_dout  <= 1'b0;
                            r_load  <= 1'b1;
                            r_state <= S_LOAD;
                        end else begin
                            r_bit  <= r_bit + BIT_W'(1);
                            r_dout <= frame_bit(r_frame, int'(r_word), int'(r_bit) + 1);
                        end
                    end
                end
                S_LOAD: begin
                    // Load lasts two divider periods; r_phase marks the second.
                    if (!w_div_wrap) begin
                        r_div <= r_div + DIV_W'(1);
                    end else if (!r_phase) begin
                        r_div   <= {DIV_W{1'b0}};
                        r_phase <= 1'b1;
                    end else begin
                        r_div   <= {DIV_W{1'b0}};
                        r_phase <= 1'b0;
                        r_load  <= 1'b0;
                        if (r_word == WORD_LAST) begin
                            r_word  <= {WORD_W{1'b0}};
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_word  <= r_word + WORD_W'(1);
                            r_dout  <= frame_bit(r_frame, int'(r_word) + 1, 0);
                            r_state <= S_SHIFT;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_dout  <= 1'b0;
                    r_load  <= 1'b0;
                    r_sclk  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_serial_dout = r_dout;
    assign o_serial_load = r_load;
    assign o_serial_clk  = r_sclk;

endmodule

// File: tb/tb_serial_display_driver.sv
// Bench for serial_display_driver: three configurations checked cycle by cycle
// against a timing model derived from the frame arithmetic.
module tb_serial_display_driver;
    localparam int PN [3] = '{2, 2, 1};
    localparam int PW [3] = '{8, 8, 4};
    localparam int PD [3] = '{2, 2, 1};
    localparam int PL [3] = '{0, 1, 0};

    logic        clk;
    logic [2:0]  st;
    logic [2:0]  en;
    logic [2:0]  rs;
    logic [15:0] dat [3];
    logic [2:0]  w_busy, w_done, w_dout, w_load, w_sclk;

    int          n_checks;
    int          n_pass;
    int          busy_cnt;
    int          load_cnt;
    int          bit_cnt;
    logic [15:0] bits_v;

    serial_display_driver #(.NUM_DIGITS(2), .WORD_BITS(8), .CLK_DIV(2), .LSB_FIRST(0)) u_msb (
        .i_clk(clk), .i_reset(rs[0]), .i_en(en[0]), .i_start(st[0]), .i_data(dat[0]),
        .o_busy(w_busy[0]), .o_done(w_done[0]), .o_serial_dout(w_dout[0]),
        .o_serial_load(w_load[0]), .o_serial_clk(w_sclk[0]));

    serial_display_driver #(.NUM_DIGITS(2), .WORD_BITS(8), .CLK_DIV(2), .LSB_FIRST(1)) u_lsb (
        .i_clk(clk), .i_reset(rs[1]), .i_en(en[1]), .i_start(st[1]), .i_data(dat[1]),
        .o_busy(w_busy[1]), .o_done(w_done[1]), .o_serial_dout(w_dout[1]),
        .o_serial_load(w_load[1]), .o_serial_clk(w_sclk[1]));

    serial_display_driver #(.NUM_DIGITS(1), .WORD_BITS(4), .CLK_DIV(1), .LSB_FIRST(0)) u_small (
        .i_clk(clk), .i_reset(rs[2]), .i_en(en[2]), .i_start(st[2]), .i_data(dat[2][3:0]),
        .o_busy(w_busy[2]), .o_done(w_done[2]), .o_serial_dout(w_dout[2]),
        .o_serial_load(w_load[2]), .o_serial_clk(w_sclk[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Outputs packed as {busy, done, dout, load, sclk}.
    function automatic logic [4:0] get_ob(input int s);
        logic [1:0] i;
        i = s[1:0];
        return {w_busy[i], w_done[i], w_dout[i], w_load[i], w_sclk[i]};
    endfunction

    function automatic int flen(input int s);
        return PN[s] * (PW[s] + 1) * 2 * PD[s];
    endfunction

    // Expected outputs in cycle k after the accepting edge (k=1 is the first busy cycle).
    function automatic logic [4:0] model(input int s, input logic [15:0] d, input int k);
        int          per_word, len, o, r, b, idx;
        logic        sclk;
        logic [15:0] tmp;
        per_word = (PW[s] + 1) * 2 * PD[s];
        len      = PN[s] * per_word;
        if (k < 1 || k > len + 1) return 5'b00000;
        if (k == len + 1) return 5'b01000;
        o = k - 1;
        r = o % per_word;
        if (r >= PW[s] * 2 * PD[s]) return 5'b10010;
        b    = r / (2 * PD[s]);
        sclk = (r % (2 * PD[s])) >= PD[s];
        idx  = (o / per_word) * PW[s] + ((PL[s] != 0) ? b : (PW[s] - 1 - b));
        tmp  = d >> idx;
        return {1'b1, 1'b0, tmp[0], 1'b0, sclk};
    endfunction

    task automatic run_frame(input int s, input logic [15:0] d, input int alt_at,
                             input int frz_at, input int frz_len, input int rst_at);
        int         len, k;
        logic [4:0] o, prev;
        len      = flen(s);
        busy_cnt = 0;
        load_cnt = 0;
        bit_cnt  = 0;
        bits_v   = 16'h0000;
        prev     = 5'b00000;
        @(negedge clk);
        dat[s] = d;
        st[s]  = 1'b1;
        @(negedge clk);
        st[s]  = 1'b0;
        k = 1;
        while (k <= len + 2) begin
            o = get_ob(s);
            chk_eq($sformatf("frame s%0d k%0d", s, k), 32'(o), 32'(model(s, d, k)));
            if (o[4]) busy_cnt++;
            if (o[1]) load_cnt++;
            if (o[0] && !prev[0]) begin
                bits_v = {bits_v[14:0], o[2]};
                bit_cnt++;
            end
            prev = o;
            if (k == rst_at) begin
                rs[s] = 1'b1;
                @(negedge clk);
                chk_eq("reset_abort", 32'(get_ob(s)), 32'd0);
                rs[s] = 1'b0;
                @(negedge clk);
                chk_eq("no_done_after_reset", 32'(get_ob(s)), 32'd0);
                return;
            end
            if (k == alt_at) begin
                st[s]  = 1'b1;
                dat[s] = ~d;
            end
            if (k == frz_at) begin
                en[s] = 1'b0;
                for (int f = 0; f < frz_len; f++) begin
                    @(negedge clk);
                    o = get_ob(s);
                    chk_eq($sformatf("frozen s%0d k%0d", s, k), 32'(o), 32'(model(s, d, k)));
                    if (o[4]) busy_cnt++;
                    if (o[1]) load_cnt++;
                end
                en[s] = 1'b1;
            end
            @(negedge clk);
            st[s] = 1'b0;
            k++;
        end
    endtask

    initial begin
        logic [15:0] d;
        int          s, fz, fl, dn;
        n_checks = 0;
        n_pass   = 0;
        st = 3'b000;
        en = 3'b111;
        rs = 3'b111;
        for (int i = 0; i < 3; i++) dat[i] = 16'h0000;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_eq($sformatf("reset_state s%0d", i), 32'(get_ob(i)), 32'd0);
        rs = 3'b000;

        run_frame(0, 16'hA53C, 0, 0, 0, 0);
        chk_eq("msb_bits", 32'(bits_v), 32'h3CA5);
        chk_eq("msb_bit_count", 32'(bit_cnt), 32'd16);
        chk_eq("msb_busy_len", 32'(busy_cnt), 32'd72);
        chk_eq("msb_load_len", 32'(load_cnt), 32'd8);

        run_frame(1, 16'hA53C, 0, 0, 0, 0);
        chk_eq("lsb_bits_a53c", 32'(bits_v), 32'h3CA5);
        run_frame(1, 16'h0180, 0, 0, 0, 0);
        chk_eq("lsb_bits_0180", 32'(bits_v), 32'h0180);
        chk_eq("lsb_busy_len", 32'(busy_cnt), 32'd72);

        run_frame(0, 16'hA53C, 10, 0, 0, 0);
        chk_eq("restart_ignored_bits", 32'(bits_v), 32'h3CA5);
        chk_eq("restart_ignored_len", 32'(busy_cnt), 32'd72);

        run_frame(0, 16'hA53C, 0, 4, 5, 0);
        chk_eq("freeze_bits", 32'(bits_v), 32'h3CA5);
        chk_eq("freeze_len", 32'(busy_cnt), 32'd77);

        run_frame(0, 16'hA53C, 0, 0, 0, 30);
        d = 16'($urandom);
        run_frame(0, d, 0, 0, 0, 0);
        chk_eq("after_reset_len", 32'(busy_cnt), 32'd72);

        for (int i = 0; i < 8; i++) begin
            s  = $urandom_range(0, 2);
            d  = 16'($urandom);
            fz = ($urandom_range(0, 1) != 0) ? $urandom_range(1, flen(s) + 1) : 0;
            fl = $urandom_range(1, 4);
            run_frame(s, d, 0, fz, fl, 0);
            chk_eq($sformatf("rand_len s%0d", s), 32'(busy_cnt),
                   32'(flen(s) + ((fz != 0 && fz <= flen(s)) ? fl : 0)));
        end

        d = 16'($urandom);
        dat[2] = d;
        dn = 0;
        @(negedge clk);
        st[2] = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 33; c++) begin
            chk_eq($sformatf("b2b c%0d", c), 32'(get_ob(2)), 32'(model(2, d, (c % 11) + 1)));
            if (w_done[2]) dn++;
            @(negedge clk);
        end
        st[2] = 1'b0;
        chk_eq("b2b_done_count", 32'(dn), 32'd3);
        repeat (12) @(negedge clk);
        chk_eq("b2b_idle_after", 32'(get_ob(2)), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
